// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// Holds the opcode map, the flag/entry records and the buffer occupancy states.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        alu_flags_t           flags;
    } alu_entry_t;

    // Occupancy of the output buffer; the encoding equals the entry count.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_result_fifo2.sv
// Two-entry valid/ready buffer of alu_entry_t records.
// in_ready and out_valid come from registered occupancy only, so there is no
// combinational path from either handshake side to the other.
module alu_result_fifo2
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  alu_entry_t in_entry,
    output logic       out_valid,
    input  logic       out_ready,
    output alu_entry_t out_entry
);

    localparam buf_state_t LAST_STATE = buf_state_t'(2'(DEPTH));

    buf_state_t state;
    buf_state_t state_next;
    logic       wr_ptr;
    logic       rd_ptr;
    alu_entry_t mem [2];
    logic       push;
    logic       pop;

    assign in_ready  = (state != LAST_STATE);
    assign out_valid = (state != BUF_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_entry = mem[rd_ptr];

    // Occupancy next-state: a simultaneous push and pop in ONE keeps the count.
    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (push) state_next = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_next = BUF_FULL;
                else if (pop && !push) state_next = BUF_EMPTY;
            end
            BUF_FULL:  if (pop) state_next = BUF_ONE;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    // Occupancy register; reset drops every buffered entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BUF_EMPTY;
        else        state <= state_next;
    end

    // Entry storage and 1-bit wrapping pointers; storage is cleared so the
    // head reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects one of eight function-unit outputs by opcode,
// derives Z/N/C/V and buffers result+flags in a two-entry output queue.
// Optional feature macro: ALU_OVF_COUNT_EN adds ovf_count, a saturating count
// of popped entries whose V flag is set.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op_sel,
    input  logic [8*WIDTH-1:0] mux_in,
    input  logic               carry_in,
    input  logic               ovf_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               flag_v
`ifdef ALU_OVF_COUNT_EN
    ,
    output logic [7:0]         ovf_count
`endif
);

    logic [WIDTH-1:0] sel_val;
    logic             is_arith;
    alu_entry_t       new_entry;
    alu_entry_t       head_entry;

    // Unit select and flag derivation; C/V only carry meaning for add/sub.
    always_comb begin
        sel_val              = mux_in[int'(op_sel)*WIDTH +: WIDTH];
        is_arith             = (op_sel == OP_ADD) || (op_sel == OP_SUB);
        new_entry.result     = sel_val;
        new_entry.flags.z    = (sel_val == '0);
        new_entry.flags.n    = sel_val[WIDTH-1];
        new_entry.flags.c    = is_arith && carry_in;
        new_entry.flags.v    = is_arith && ovf_in;
    end

    alu_result_fifo2 #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_entry (new_entry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_entry(head_entry)
    );

    assign result = head_entry.result;
    assign flag_z = head_entry.flags.z;
    assign flag_n = head_entry.flags.n;
    assign flag_c = head_entry.flags.c;
    assign flag_v = head_entry.flags.v;

`ifdef ALU_OVF_COUNT_EN
    // Count popped entries with V set, holding at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= 8'd0;
        end else if (out_valid && out_ready && head_entry.flags.v && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule
